// File: rtl/int_gateway.sv
// Interrupt gateway: edge/level pending capture, enable masking, fixed-priority
// arbitration and a claim/complete register port feeding clint.int_flag_i.
module int_gateway #(
  parameter  int unsigned NUM_SRC = 8,
  parameter  int unsigned INT_W   = 8,
  localparam int unsigned AW      = 8,
  localparam int unsigned DW      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [DW-1:0]      wdata_i,
  output logic [DW-1:0]      rdata_o,
  output logic               ack_o,
  output logic [INT_W-1:0]   int_flag_o
);

  localparam int unsigned WW = AW - 2;
  localparam logic [WW-1:0] REG_PENDING  = WW'(0);
  localparam logic [WW-1:0] REG_ENABLE   = WW'(1);
  localparam logic [WW-1:0] REG_EDGE     = WW'(2);
  localparam logic [WW-1:0] REG_INFLIGHT = WW'(3);
  localparam logic [WW-1:0] REG_CLAIM    = WW'(4);

  logic [NUM_SRC-1:0] pending, enable, edge_cfg, inflight, irq_q;
  logic [NUM_SRC-1:0] pending_n, enable_n, edge_n, inflight_n;
  logic [NUM_SRC-1:0] cand, best_oh, claim_oh, done_oh, edge_chg, rise;
  logic [INT_W-1:0]   best_id;
  logic               found;
  logic [WW-1:0]      word;
  logic               rd_claim, wr_enable, wr_edge, wr_complete, busy;
  logic [DW-1:0]      rd_val;
  logic               unused_bits;

  assign unused_bits = ^{addr_i[1:0], wdata_i};

  // Register decode; byte lanes below bit 2 are ignored
  assign word        = addr_i[AW-1:2];
  assign rd_claim    = req_i & ~we_i & (word == REG_CLAIM);
  assign wr_complete = req_i &  we_i & (word == REG_CLAIM);
  assign wr_enable   = req_i &  we_i & (word == REG_ENABLE);
  assign wr_edge     = req_i &  we_i & (word == REG_EDGE);

  assign cand     = pending & enable;
  assign rise     = irq_i & ~irq_q;
  assign busy     = |inflight;
  assign edge_chg = wr_edge ? (edge_cfg ^ wdata_i[NUM_SRC-1:0]) : '0;
  assign enable_n = wr_enable ? wdata_i[NUM_SRC-1:0] : enable;
  assign edge_n   = wr_edge ? wdata_i[NUM_SRC-1:0] : edge_cfg;

  // Lowest-index enabled pending source wins
  always_comb begin
    best_id = '0;
    best_oh = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cand[i] && !found) begin
        found      = 1'b1;
        best_id    = INT_W'(i + 1);
        best_oh[i] = 1'b1;
      end
    end
  end

  assign claim_oh = rd_claim ? best_oh : '0;

  // Complete only releases a source that is actually in service
  always_comb begin
    done_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      done_oh[i] = wr_complete && (wdata_i[4:0] == 5'(i + 1)) && inflight[i];
    end
  end

  assign inflight_n = (inflight | claim_oh) & ~done_oh;

  // Pending capture uses the current inflight, so same-cycle edges are dropped
  always_comb begin
    pending_n = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (edge_chg[i] || claim_oh[i]) begin
        pending_n[i] = 1'b0;
      end else if (inflight[i]) begin
        pending_n[i] = edge_cfg[i] & pending[i];
      end else if (edge_cfg[i]) begin
        pending_n[i] = pending[i] | rise[i];
      end else begin
        pending_n[i] = irq_i[i];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (word)
      REG_PENDING:  rd_val = DW'(pending);
      REG_ENABLE:   rd_val = DW'(enable);
      REG_EDGE:     rd_val = DW'(edge_cfg);
      REG_INFLIGHT: rd_val = DW'(inflight);
      REG_CLAIM:    rd_val = DW'(best_id);
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      enable     <= '0;
      edge_cfg   <= '0;
      inflight   <= '0;
      irq_q      <= '0;
      int_flag_o <= '0;
      ack_o      <= 1'b0;
      rdata_o    <= '0;
    end else begin
      pending    <= pending_n;
      enable     <= enable_n;
      edge_cfg   <= edge_n;
      inflight   <= inflight_n;
      irq_q      <= irq_i;
      int_flag_o <= busy ? '0 : best_id;
      ack_o      <= req_i;
      rdata_o    <= (req_i && !we_i) ? rd_val : '0;
    end
  end

endmodule
